// File: rtl/jelly_crc_pkg.sv
// Shared CRC helpers and presets for jelly_crc_stream; optional checker feature is JELLY_CRC_STREAM_CHECK_EN.
// Functions work on a 64-bit container; only the low `width` bits are meaningful.
package jelly_crc_pkg;

    typedef struct packed {
        logic [7:0]  width;
        logic [63:0] poly;
        logic [63:0] init;
        logic [63:0] xor_out;
        logic        reflect_in;
        logic        reflect_out;
    } crc_preset_t;

    localparam crc_preset_t CRC32_ETH = '{
        width: 8'd32, poly: 64'h04C11DB7, init: 64'hFFFFFFFF, xor_out: 64'hFFFFFFFF,
        reflect_in: 1'b1, reflect_out: 1'b1
    };

    localparam crc_preset_t CRC16_CCITT_FALSE = '{
        width: 8'd16, poly: 64'h1021, init: 64'hFFFF, xor_out: 64'h0000,
        reflect_in: 1'b0, reflect_out: 1'b0
    };

    localparam crc_preset_t CRC8_ATM = '{
        width: 8'd8, poly: 64'h07, init: 64'h00, xor_out: 64'h00,
        reflect_in: 1'b0, reflect_out: 1'b0
    };

    // Reverses the low `width` bits; upper bits of the result are zero.
    function automatic logic [63:0] bit_reverse(input logic [63:0] value, input int unsigned width);
        logic [63:0] v;
        logic [63:0] r;
        v = value;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width) begin
                r = {r[62:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] crc_byte_update(
        input logic [63:0]  crc,
        input logic [7:0]   data,
        input logic [63:0]  poly,
        input int unsigned  width,
        input logic         reflect_in
    );
        logic [63:0] mask;
        logic [63:0] c;
        logic [7:0]  b;
        logic        fb;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        b    = reflect_in ? 8'(bit_reverse(64'(data), 8)) : data;
        c    = crc & mask;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = (((c >> (width - 1)) & 64'd1) != 64'd0) ^ b[7];
            c  = (c << 1) & mask;
            if (fb) begin
                c = c ^ (poly & mask);
            end
            b = {b[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/jelly_crc_stream_lanes.sv
// Combinational fold of up to BYTE_LANES bytes (lane 0 first) into a CRC register value.
// Part of jelly_crc_stream; unaffected by JELLY_CRC_STREAM_CHECK_EN.
module jelly_crc_stream_lanes
    import jelly_crc_pkg::*;
#(
    parameter int unsigned          BYTE_LANES = 4,
    parameter int unsigned          CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = 32'h04C11DB7,
    parameter bit                   REFLECT_IN = 1'b1
) (
    input  logic [CRC_WIDTH-1:0]    crc_in,
    input  logic [BYTE_LANES*8-1:0] data,
    input  logic [BYTE_LANES-1:0]   keep,
    output logic [CRC_WIDTH-1:0]    crc_out
);

    logic [63:0]             crc_acc;
    logic [BYTE_LANES*8-1:0] data_sh;
    logic [BYTE_LANES-1:0]   keep_sh;

    // Lanes are consumed from the bottom by shifting, so lane order matches stream order.
    always_comb begin
        crc_acc = 64'(crc_in);
        data_sh = data;
        keep_sh = keep;
        for (int unsigned k = 0; k < BYTE_LANES; k++) begin
            if (keep_sh[0]) begin
                crc_acc = crc_byte_update(crc_acc, data_sh[7:0], 64'(POLY), CRC_WIDTH, REFLECT_IN);
            end
            data_sh = data_sh >> 8;
            keep_sh = keep_sh >> 1;
        end
        crc_out = crc_acc[CRC_WIDTH-1:0];
    end

endmodule

// File: rtl/jelly_crc_stream.sv
// Streaming frame CRC generator: ready/valid byte beats in, one CRC word per frame out.
// Define JELLY_CRC_STREAM_CHECK_EN to add the s_check/m_match comparator.
module jelly_crc_stream
    import jelly_crc_pkg::*;
#(
    parameter int unsigned          BYTE_LANES  = 4,
    parameter int unsigned          DATA_WIDTH  = BYTE_LANES * 8,
    parameter int unsigned          CRC_WIDTH   = 32,
    parameter logic [CRC_WIDTH-1:0] POLY        = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT        = 32'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit                   REFLECT_IN  = 1'b1,
    parameter bit                   REFLECT_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [BYTE_LANES-1:0] s_keep,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
`ifdef JELLY_CRC_STREAM_CHECK_EN
    input  logic [CRC_WIDTH-1:0]  s_check,
    output logic                  m_match,
`endif
    output logic [CRC_WIDTH-1:0]  m_crc,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic                  in_frame_q, in_frame_d;
    logic [CRC_WIDTH-1:0]  m_crc_q, m_crc_d;
    logic                  m_valid_q, m_valid_d;
`ifdef JELLY_CRC_STREAM_CHECK_EN
    logic                  m_match_q, m_match_d;
`endif

    logic [CRC_WIDTH-1:0]  crc_src;
    logic [CRC_WIDTH-1:0]  crc_fold;
    logic [CRC_WIDTH-1:0]  crc_final;
    logic [63:0]           crc_ext;
    logic                  s_accept;
    logic                  m_accept;
    logic [BYTE_LANES-1:0] keep_inc;

    assign s_ready = !m_valid_q || m_ready;
    assign m_crc   = m_crc_q;
    assign m_valid = m_valid_q;
`ifdef JELLY_CRC_STREAM_CHECK_EN
    assign m_match = m_match_q;
`endif

    jelly_crc_stream_lanes #(
        .BYTE_LANES (BYTE_LANES),
        .CRC_WIDTH  (CRC_WIDTH),
        .POLY       (POLY),
        .REFLECT_IN (REFLECT_IN)
    ) u_lanes (
        .crc_in  (crc_src),
        .data    (s_data),
        .keep    (s_keep),
        .crc_out (crc_fold)
    );

    always_comb begin
        s_accept = s_valid && s_ready && cke;
        m_accept = m_valid_q && m_ready && cke;
        crc_src  = in_frame_q ? crc_q : INIT;
        keep_inc = s_keep + BYTE_LANES'(1);
        crc_ext  = 64'(crc_fold);
        if (REFLECT_OUT) begin
            crc_ext = bit_reverse(crc_ext, CRC_WIDTH);
        end
        crc_final = crc_ext[CRC_WIDTH-1:0] ^ XOR_OUT;
    end

    // A new result takes priority over retiring the old one, so a same-cycle
    // output handshake and last beat leave m_valid asserted with the new CRC.
    always_comb begin
        crc_d      = crc_q;
        in_frame_d = in_frame_q;
        m_crc_d    = m_crc_q;
        m_valid_d  = m_valid_q;
`ifdef JELLY_CRC_STREAM_CHECK_EN
        m_match_d  = m_match_q;
`endif
        if (m_accept) begin
            m_valid_d = 1'b0;
        end
        if (s_accept) begin
            if (s_last) begin
                m_crc_d    = crc_final;
                m_valid_d  = 1'b1;
                crc_d      = INIT;
                in_frame_d = 1'b0;
`ifdef JELLY_CRC_STREAM_CHECK_EN
                m_match_d  = (crc_final == s_check);
`endif
            end else begin
                crc_d      = crc_fold;
                in_frame_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q      <= INIT;
            in_frame_q <= 1'b0;
            m_crc_q    <= '0;
            m_valid_q  <= 1'b0;
`ifdef JELLY_CRC_STREAM_CHECK_EN
            m_match_q  <= 1'b0;
`endif
        end else begin
            crc_q      <= crc_d;
            in_frame_q <= in_frame_d;
            m_crc_q    <= m_crc_d;
            m_valid_q  <= m_valid_d;
`ifdef JELLY_CRC_STREAM_CHECK_EN
            m_match_q  <= m_match_d;
`endif
        end
    end

    // Keep mask must be a run of ones starting at lane 0.
    a_keep_contiguous: assert property (
        @(posedge clk) disable iff (!reset_n)
        s_accept |-> ((s_keep & keep_inc) == '0)
    );

endmodule

// File: tb/tb_jelly_crc_stream.sv
// Self-checking bench for jelly_crc_stream (CRC-32 default instance plus a CRC-16/CCITT-FALSE instance).
`timescale 1ns/1ps
module tb_jelly_crc_stream;

    localparam int unsigned LANES = 4;
    typedef logic [7:0] byte_q_t[$];

    localparam logic [31:0] STR_DATA [3] = '{32'h34333231, 32'h38373635, 32'h00000039};
    localparam logic [3:0]  STR_KEEP [3] = '{4'b1111, 4'b1111, 4'b0001};
    localparam logic [31:0] CRC_STR  = 32'hCBF43926;
    localparam logic [31:0] CRC_ZERO = 32'hD202EF8D;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cke;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last, s_valid, s_ready;
    logic [31:0] m_crc;
    logic        m_valid, m_ready;
`ifdef JELLY_CRC_STREAM_CHECK_EN
    logic [31:0] s_check;
    logic        m_match;
    logic [15:0] b_check;
    logic        b_match;
`endif

    logic [7:0]  b_data;
    logic [0:0]  b_keep;
    logic        b_last, b_valid, b_ready;
    logic [15:0] b_crc;
    logic        b_mvalid, b_mready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jelly_crc_stream #(
        .BYTE_LANES (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
`ifdef JELLY_CRC_STREAM_CHECK_EN
        .s_check (s_check),
        .m_match (m_match),
`endif
        .m_crc   (m_crc),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    jelly_crc_stream #(
        .BYTE_LANES  (1),
        .CRC_WIDTH   (16),
        .POLY        (16'h1021),
        .INIT        (16'hFFFF),
        .XOR_OUT     (16'h0000),
        .REFLECT_IN  (1'b0),
        .REFLECT_OUT (1'b0)
    ) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .s_data  (b_data),
        .s_keep  (b_keep),
        .s_last  (b_last),
        .s_valid (b_valid),
        .s_ready (b_ready),
`ifdef JELLY_CRC_STREAM_CHECK_EN
        .s_check (b_check),
        .m_match (b_match),
`endif
        .m_crc   (b_crc),
        .m_valid (b_mvalid),
        .m_ready (b_mready)
    );

    // Reference CRC-32/Ethernet in the reflected LSB-first formulation.
    function automatic logic [31:0] ref_crc32(input byte_q_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_keep  = '0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        cke      = 1'b1;
        m_ready  = 1'b0;
        b_mready = 1'b0;
        b_valid  = 1'b0;
        b_keep   = '0;
        b_last   = 1'b0;
        b_data   = '0;
`ifdef JELLY_CRC_STREAM_CHECK_EN
        s_check  = '0;
        b_check  = '0;
`endif
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        checks++; if (m_crc !== 32'h0) begin errors++; $display("FAIL reset_m_crc: got %h want 00000000", m_crc); end
        checks++; if (b_mvalid !== 1'b0) begin errors++; $display("FAIL reset_m_valid16: got %b want 0", b_mvalid); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL post_reset_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_string();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = STR_DATA[i]; s_keep = STR_KEEP[i]; s_last = (i == 2);
            #1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL string_s_ready beat%0d: got %b want 1", i, s_ready); end
            if (i == 2) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL string_early_valid: got %b want 0", m_valid); end
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL string_m_valid: got %b want 1", m_valid); end
        checks++; if (m_crc !== CRC_STR) begin errors++; $display("FAIL string_crc: got %h want %h", m_crc, CRC_STR); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL string_hold: got %b want 1", m_valid); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL string_consume: got %b want 0", m_valid); end
    endtask

    task automatic test_crc16();
        b_mready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_valid = 1'b1; b_data = 8'h31 + 8'(i); b_keep = 1'b1; b_last = (i == 8);
            #1;
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL crc16_s_ready beat%0d: got %b want 1", i, b_ready); end
            @(negedge clk);
        end
        b_valid = 1'b0; b_last = 1'b0; b_keep = '0;
        checks++; if (b_mvalid !== 1'b1) begin errors++; $display("FAIL crc16_m_valid: got %b want 1", b_mvalid); end
        checks++; if (b_crc !== 16'h29B1) begin errors++; $display("FAIL crc16_crc: got %h want 29b1", b_crc); end
        b_mready = 1'b1;
        @(negedge clk);
        b_mready = 1'b0;
        checks++; if (b_mvalid !== 1'b0) begin errors++; $display("FAIL crc16_consume: got %b want 0", b_mvalid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        logic [3:0]  k [4];
        logic        l [4];
        d = '{32'h00000000, STR_DATA[0], STR_DATA[1], STR_DATA[2]};
        k = '{4'b0001, STR_KEEP[0], STR_KEEP[1], STR_KEEP[2]};
        l = '{1'b1, 1'b0, 1'b0, 1'b1};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = d[i]; s_keep = k[i]; s_last = l[i];
            #1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready beat%0d: got %b want 1", i, s_ready); end
            if (i == 1) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b want 1", m_valid); end
                checks++; if (m_crc !== CRC_ZERO) begin errors++; $display("FAIL b2b_first_crc: got %h want %h", m_crc, CRC_ZERO); end
            end
            if (i == 2) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid: got %b want 0", m_valid); end
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", m_valid); end
        checks++; if (m_crc !== CRC_STR) begin errors++; $display("FAIL b2b_second_crc: got %h want %h", m_crc, CRC_STR); end
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_stall();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = STR_DATA[i]; s_keep = STR_KEEP[i]; s_last = (i == 2);
            @(negedge clk);
        end
        s_data = 32'h0; s_keep = 4'b0001; s_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready cyc%0d: got %b want 0", c, s_ready); end
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid cyc%0d: got %b want 1", c, m_valid); end
            checks++; if (m_crc !== CRC_STR) begin errors++; $display("FAIL stall_m_crc cyc%0d: got %h want %h", c, m_crc, CRC_STR); end
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", s_ready); end
        @(negedge clk);
        m_ready = 1'b0;
        idle_inputs();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_overwrite_valid: got %b want 1", m_valid); end
        checks++; if (m_crc !== CRC_ZERO) begin errors++; $display("FAIL stall_overwrite_crc: got %h want %h", m_crc, CRC_ZERO); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = STR_DATA[0]; s_keep = STR_KEEP[0]; s_last = 1'b0;
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid_hold: got %b want 0", m_valid); end
        reset_n = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = STR_DATA[i]; s_keep = STR_KEEP[i]; s_last = (i == 2);
            @(negedge clk);
        end
        idle_inputs();
        checks++; if (m_crc !== CRC_STR) begin errors++; $display("FAIL midrst_crc: got %h want %h", m_crc, CRC_STR); end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

`ifdef JELLY_CRC_STREAM_CHECK_EN
    task automatic test_check_en();
        logic [31:0] chk [2];
        logic        want [2];
        chk  = '{CRC_STR, CRC_STR + 32'd1};
        want = '{1'b1, 1'b0};
        m_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            s_check = chk[f];
            for (int i = 0; i < 3; i++) begin
                s_valid = 1'b1; s_data = STR_DATA[i]; s_keep = STR_KEEP[i]; s_last = (i == 2);
                @(negedge clk);
            end
            idle_inputs();
            s_check = '0;
            checks++; if (m_match !== want[f]) begin errors++; $display("FAIL check_en_match%0d: got %b want %b", f, m_match, want[f]); end
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask
`endif

    task automatic test_random();
        byte_q_t     pend;
        logic        exp_valid;
        logic [31:0] exp_crc;
        logic        exp_ready, acc, done;
        int unsigned n;
        exp_valid = 1'b0;
        exp_crc   = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (m_valid !== exp_valid) begin errors++; $display("FAIL rand_m_valid cyc%0d: got %b want %b", cyc, m_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (m_crc !== exp_crc) begin errors++; $display("FAIL rand_m_crc cyc%0d: got %h want %h", cyc, m_crc, exp_crc); end
            end
            n       = $urandom_range(0, LANES);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom();
            s_keep  = 4'((5'd1 << n) - 5'd1);
            s_last  = ($urandom_range(0, 2) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            cke     = ($urandom_range(0, 7) != 0);
            #1;
            exp_ready = !exp_valid || m_ready;
            checks++; if (s_ready !== exp_ready) begin errors++; $display("FAIL rand_s_ready cyc%0d: got %b want %b", cyc, s_ready, exp_ready); end
            acc  = s_valid && exp_ready && cke;
            done = exp_valid && m_ready && cke;
            if (acc) begin
                for (int k = 0; k < int'(n); k++) pend.push_back(s_data[8*k +: 8]);
            end
            if (acc && s_last) begin
                exp_crc   = ref_crc32(pend);
                exp_valid = 1'b1;
                pend.delete();
            end else if (done) begin
                exp_valid = 1'b0;
            end
            @(negedge clk);
        end
        idle_inputs();
        cke     = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_drain: got %b want 0", m_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_string();
        test_crc16();
        test_back_to_back();
        test_stall();
        test_reset_midframe();
`ifdef JELLY_CRC_STREAM_CHECK_EN
        test_check_en();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jelly_crc_stream.md
Name: jelly_crc_stream

Overview:
- Streaming, frame-oriented CRC generator that processes up to DATA_WIDTH/8 bytes per clock.
- Polynomial, init value, reflection and output XOR are all parametrised.
- Sits beside packet datapaths (Ethernet/UART/storage framing) as a side-tap: consumes a ready/valid byte stream with keep and last, and emits one CRC word per frame on its own ready/valid output.

Parameters:
- BYTE_LANES, 4, bytes per input beat (1..16).
- DATA_WIDTH, BYTE_LANES*8, input data width (derived; do not override).
- CRC_WIDTH, 32, CRC width in bits (8..64).
- POLY, 32'h04C11DB7, polynomial in normal (MSB-first) form, CRC_WIDTH bits.
- INIT, 32'hFFFFFFFF, register value at frame start.
- XOR_OUT, 32'hFFFFFFFF, XORed into the final register.
- REFLECT_IN, 1, 1: each byte processed LSB-first.
- REFLECT_OUT, 1, 1: final register bit-reversed before XOR_OUT.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- cke, input, 1, clock enable; when 0, all state holds.
- s_data, input, DATA_WIDTH, byte lane k = s_data[8k+7:8k]; lane 0 is first in the stream.
- s_keep, input, BYTE_LANES, lane valid mask; must be contiguous from lane 0.
- s_last, input, 1, final beat of frame.
- s_valid, input, 1, beat valid.
- s_ready, output, 1, beat accepted when s_valid & s_ready & cke.
- m_crc, output, CRC_WIDTH, finished CRC.
- m_valid, output, 1, result valid.
- m_ready, input, 1, result consumed.

Behaviour:
- Reset (async assert, sync release): crc_reg=INIT, in_frame=0, m_valid=0, m_crc=0. s_ready reflects m_valid=0, so it reads 1.
- s_ready = !m_valid || m_ready. Purely combinational from state and m_ready; no dependence on s_valid.
- Accepted beat: lanes with s_keep[k]=1 are folded into crc_reg in order lane0..lane(N-1).
  - Source register is INIT if in_frame=0, else crc_reg.
  - Fold is a combinational unrolled bitwise update per byte: 8 shift/XOR steps with POLY, MSB-first; REFLECT_IN bit-reverses each byte first.
- Accepted beat with s_last=0: crc_reg <= folded value, in_frame <= 1.
- Accepted beat with s_last=1:
  - m_crc <= reflect_out(folded) ^ XOR_OUT; m_valid <= 1 next cycle (latency 1 from last beat).
  - crc_reg <= INIT, in_frame <= 0.
  - Back-to-back frames are legal with no bubble.
- s_keep=0 beat: no data folded. With s_last=1 it still emits a result (INIT-based if the frame is empty).
- Non-contiguous s_keep: undefined result; a simulation-only assertion flags it.
- m_valid held until m_valid & m_ready & cke. While m_valid=1 and m_ready=0, input stalls (s_ready=0).
- Simultaneous output handshake and new last beat: the new result overwrites m_crc and m_valid stays 1.
- cke=0: no handshake completes, and registers hold regardless of valid/ready.
- reset_n assertion mid-frame aborts the partial CRC. The next accepted beat starts a new frame from INIT.

Optional Feature:
- Macro JELLY_CRC_STREAM_CHECK_EN.
- When defined, adds ports:
  - s_check input CRC_WIDTH, sampled on the last beat.
  - m_match output 1, registered alongside m_crc; 1 when the computed CRC equals s_check.
  - m_match resets to 0.
- When undefined, these ports and the comparator do not exist and the behaviour above is unchanged.

Decomposition:
- Package jelly_crc_pkg:
  - function crc_byte_update (crc, byte, poly, width, reflect_in).
  - function bit_reverse.
  - localparams for standard presets: CRC32_ETH, CRC16_CCITT_FALSE, CRC8_ATM.
- One sub-module: jelly_crc_stream_lanes, the combinational fold of BYTE_LANES bytes with keep masking into a CRC. Top level holds the framing registers and handshake.

Test Plan:
- Defaults, ASCII "123456789" as beats keep=1111, 1111, 0001 with last on the third beat -> m_crc=32'hCBF43926 one cycle after the last beat.
- CRC_WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, XOR_OUT=0, REFLECT_IN=REFLECT_OUT=0, BYTE_LANES=1, nine bytes "123456789" -> m_crc=16'h29B1.
- Defaults, single beat data byte 8'h00, keep=0001, last -> 32'hD202EF8D; then immediately the "123456789" frame -> 32'hCBF43926; both results delivered in order with no input bubble.
- Hold m_ready=0 after a result -> s_ready=0 and the next last beat stalls; release m_ready -> first result consumed, then the second result appears with correct value.
- Assert reset_n low after the first beat of "123456789", release, send the full frame -> 32'hCBF43926 and m_valid=0 during reset.
- With JELLY_CRC_STREAM_CHECK_EN: "123456789", s_check=32'hCBF43926 -> m_match=1; s_check=32'hCBF43927 -> m_match=0.
